// File: rtl/alu_pkg.sv
// Shared ALU control codes, execute-FSM state type and opcode helper for alu_exec/alu_core.
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b1001;
  localparam logic [3:0] ALU_SRL  = 4'b1010;
  localparam logic [3:0] ALU_SRA  = 4'b1011;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  function automatic logic is_shift_op(input logic [3:0] ctrl);
    return (ctrl == ALU_SLL) || (ctrl == ALU_SRL) || (ctrl == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational single-cycle ALU. Shifts are only built here when ALU_EXEC_FAST_SHIFT_EN
// is defined; otherwise the shift codes return 0 and alu_exec iterates them.
module alu_core
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic [XLEN-1:0] y
);

`ifdef ALU_EXEC_FAST_SHIFT_EN
  localparam int SHW = $clog2(XLEN);
`endif

  always_comb begin
    y = '0;
    case (alu_ctrl)
      ALU_AND:  y = op_a & op_b;
      ALU_OR:   y = op_a | op_b;
      ALU_ADD:  y = op_a + op_b;
      ALU_XOR:  y = op_a ^ op_b;
      ALU_SUB:  y = op_a - op_b;
      ALU_SLT:  y = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      ALU_SLTU: y = {{(XLEN-1){1'b0}}, (op_a < op_b)};
`ifdef ALU_EXEC_FAST_SHIFT_EN
      ALU_SLL:  y = op_a << op_b[SHW-1:0];
      ALU_SRL:  y = op_a >> op_b[SHW-1:0];
      ALU_SRA:  y = $signed(op_a) >>> op_b[SHW-1:0];
`else
      ALU_SLL, ALU_SRL, ALU_SRA: y = '0;
`endif
      default:  y = '0;
    endcase
  end

endmodule

// File: rtl/alu_exec.sv
// ALU execute stage with valid/ready handshake and a bit-serial shifter.
// Defining ALU_EXEC_FAST_SHIFT_EN moves shifts into alu_core so SHIFT is never entered.
//
// state    | meaning
// ST_IDLE  | no result held, ready for a request
// ST_SHIFT | shifting result_q one bit per cycle, cnt_q bits remaining
// ST_DONE  | result valid, held until out_ready
module alu_exec
  import alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SHW  = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            busy
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            zero_q, zero_d;
  logic            out_valid_q, out_valid_d;
  logic            busy_q, busy_d;
  logic [SHW-1:0]  cnt_q, cnt_d;
  logic [3:0]      op_q, op_d;

  logic [XLEN-1:0] core_y;
  logic [XLEN-1:0] load_val;
  logic [XLEN-1:0] shift_val;
  logic            go_shift;
  logic            accept;

  alu_core #(.XLEN(XLEN)) u_core (
    .alu_ctrl (alu_ctrl),
    .op_a     (op_a),
    .op_b     (op_b),
    .y        (core_y)
  );

  assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign busy      = busy_q;

  // Shift-by-zero needs no iteration: op_a is already the answer.
  always_comb begin
    go_shift = 1'b0;
    load_val = core_y;
`ifdef ALU_EXEC_FAST_SHIFT_EN
    go_shift = 1'b0;
`else
    if (is_shift_op(alu_ctrl)) begin
      go_shift = (op_b[SHW-1:0] != '0);
      load_val = op_a;
    end
`endif
  end

  always_comb begin
    case (op_q)
      ALU_SLL: shift_val = {result_q[XLEN-2:0], 1'b0};
      ALU_SRA: shift_val = {result_q[XLEN-1], result_q[XLEN-1:1]};
      default: shift_val = {1'b0, result_q[XLEN-1:1]};
    endcase
  end

  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    zero_d      = zero_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    out_valid_d = 1'b0;
    busy_d      = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if ((state_q == ST_DONE) && !out_ready) begin
          out_valid_d = 1'b1;
        end else if (accept) begin
          op_d     = alu_ctrl;
          result_d = load_val;
          cnt_d    = go_shift ? op_b[SHW-1:0] : '0;
          if (go_shift) begin
            state_d = ST_SHIFT;
            busy_d  = 1'b1;
          end else begin
            state_d     = ST_DONE;
            out_valid_d = 1'b1;
            zero_d      = (load_val == '0);
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        result_d = shift_val;
        cnt_d    = cnt_q - 1'b1;
        if (cnt_q == {{(SHW-1){1'b0}}, 1'b1}) begin
          state_d     = ST_DONE;
          out_valid_d = 1'b1;
          zero_d      = (shift_val == '0);
        end else begin
          busy_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      result_q    <= '0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      cnt_q       <= '0;
      op_q        <= ALU_AND;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
    end
  end

endmodule

// File: doc/alu_exec.md
ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, datapath width in bits.
REQ-002 The block SHALL have parameter SHW, default 5, shift-amount width, equal to log2(XLEN).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, reset; it is synchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1, the operation request.
REQ-006 The block SHALL have port in_ready, output, 1, the block can accept a request this cycle.
REQ-007 The block SHALL have port alu_ctrl, input, 4, the ALU control code from the ALU control decoder.
REQ-008 The block SHALL have ports op_a and op_b, input, XLEN each, the operands.
REQ-009 The block SHALL have port out_valid, output, 1, result and zero are valid.
REQ-010 The block SHALL have port out_ready, input, 1, the consumer accepts the result.
REQ-011 The block SHALL have port result, output, XLEN, the registered result.
REQ-012 The block SHALL have port zero, output, 1, the registered (result == 0) flag used for branch compare.
REQ-013 The block SHALL have port busy, output, 1, high while in the SHIFT state.

Function
REQ-014 A request SHALL be accepted in a cycle where in_valid and in_ready are both high; operands and alu_ctrl are captured on that edge.
REQ-015 alu_ctrl SHALL decode as follows, with any other code giving result 0:
- 0000: AND
- 0001: OR
- 0010: ADD
- 0011: XOR
- 0110: SUB
- 0111: SLT (signed, result 1 or 0)
- 1000: SLTU
- 1001: SLL
- 1010: SRL
- 1011: SRA
REQ-016 Arithmetic SHALL wrap modulo 2^XLEN with no overflow flag; the shift amount is op_b[SHW-1:0] and the upper bits of op_b are ignored for shifts.
REQ-017 The FSM SHALL have three states, IDLE, SHIFT and DONE, with these transitions:
- IDLE to DONE on accepting a non-shift op, or a shift with amount 0.
- IDLE to SHIFT on accepting a shift with amount k > 0.
- SHIFT to DONE after k cycles of SHIFT.
REQ-018 In SHIFT, the accumulator SHALL shift by one bit per cycle and the counter SHALL decrement; SRA replicates the sign bit and SRL/SLL fill with 0.
REQ-019 Latency, for acceptance at edge N:
- Non-shift ops: out_valid high from cycle N+1.
- Shift by k: out_valid high from cycle N+1+k.
REQ-020 out_valid SHALL be high only in DONE; result and zero are held stable until out_valid && out_ready.
REQ-021 in_ready SHALL equal (state==IDLE) || (state==DONE && out_ready).
REQ-022 When DONE, out_ready and in_valid are all high, the block SHALL retire the current result and accept the new request on the same edge, giving back-to-back throughput of one per cycle for non-shift ops.
REQ-023 When DONE with out_ready high and in_valid low, the block SHALL return to IDLE.
REQ-024 Input changes during SHIFT or while DONE is stalled SHALL have no effect on the result.

Reset
REQ-025 While rst is high on an edge, the block SHALL set state to IDLE, and set out_valid, result, zero, busy and the shift counter to 0.
REQ-026 rst asserted mid-SHIFT or mid-DONE SHALL abort the operation with no output produced, and in_ready SHALL be 1 on the cycle after reset deasserts.

Configuration
REQ-027 With macro ALU_EXEC_FAST_SHIFT_EN defined, shifts SHALL use a single-cycle barrel shifter with the same latency as other ops; SHIFT is never entered and busy stays 0.
REQ-028 Without ALU_EXEC_FAST_SHIFT_EN, the iterative shifter of REQ-017 to REQ-019 SHALL be built.

Structure
REQ-029 A shared package alu_pkg SHALL hold the 4-bit alu_ctrl code constants (named per REQ-015) and the FSM state enum type.
REQ-030 The block SHALL contain one sub-module, alu_core: a combinational single-cycle ALU for all non-iterative ops, instantiated by alu_exec.

Verification
REQ-031 ADD, op_a=0x7FFFFFFF, op_b=1: out_valid at N+1, result=0x80000000, zero=0.
REQ-032 SUB, op_a=op_b=0x1234: result=0 and zero=1; SLT 0xFFFFFFFF vs 1 gives 1; SLTU with the same operands gives 0.
REQ-033 SRA, op_a=0x80000000, op_b=0x24 (amount 4), iterative build:
- busy high for 4 cycles.
- out_valid at N+5.
- result=0xF8000000.
- Shift amount 0 completes at N+1 with result=op_a.
REQ-034 out_ready held low for 3 cycles in DONE: result stays stable and in_ready=0; on out_ready=1 with in_valid=1 (XOR 0xFF, 0x0F), the next cycle shows result=0xF0.
REQ-035 rst pulsed during SLL by 20: no out_valid is produced, all outputs are 0, and a following ADD 2+3 returns 5 at N+1.
REQ-036 ALU_EXEC_FAST_SHIFT_EN defined: SRL 0x80000000 by 31 completes at N+1 with result=1; an illegal code 0101 returns result 0 with zero=1.
